// File: rtl/trap_ctrl_pkg.sv
// Shared exception/trap definitions: the except_t flag vector raised by the
// pipeline stages, cause codes, privilege levels and the trap FSM encoding.
package trap_ctrl_pkg;

  typedef struct packed {
    logic breakpoint;
    logic fetch_pagefault;
    logic fetch_access_fault;
    logic illegal_inst;
    logic fetch_misalign;
    logic ecall;
    logic store_misalign;
    logic load_misalign;
    logic store_pagefault;
    logic load_pagefault;
    logic store_access_fault;
    logic load_access_fault;
    logic mret;
    logic sret;
    logic uret;
  } except_t;

  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } priv_t;

  localparam logic [4:0] EXC_FETCH_MISALIGN  = 5'd0;
  localparam logic [4:0] EXC_FETCH_ACCESS    = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL_INST    = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT      = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN   = 5'd4;
  localparam logic [4:0] EXC_LOAD_ACCESS     = 5'd5;
  localparam logic [4:0] EXC_STORE_MISALIGN  = 5'd6;
  localparam logic [4:0] EXC_STORE_ACCESS    = 5'd7;
  localparam logic [4:0] EXC_ECALL_BASE      = 5'd8;
  localparam logic [4:0] EXC_FETCH_PAGEFAULT = 5'd12;
  localparam logic [4:0] EXC_LOAD_PAGEFAULT  = 5'd13;
  localparam logic [4:0] EXC_STORE_PAGEFAULT = 5'd15;

  localparam logic [4:0] IRQ_SSI = 5'd1;
  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_STI = 5'd5;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_SEI = 5'd9;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  // Bit positions inside irq_pending, ordered {mei,msi,mti,sei,ssi,sti}
  localparam int IRQ_BIT_MEI = 5;
  localparam int IRQ_BIT_MSI = 4;
  localparam int IRQ_BIT_MTI = 3;
  localparam int IRQ_BIT_SEI = 2;
  localparam int IRQ_BIT_SSI = 1;
  localparam int IRQ_BIT_STI = 0;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } trap_state_t;

  typedef enum logic [1:0] {
    XRET_U = 2'd0,
    XRET_S = 2'd1,
    XRET_M = 2'd3
  } xret_kind_t;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational priority encoder: picks the winning interrupt, exception or
// xret for the committing instruction and produces its cause code.
module trap_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IRQ_W = 6
) (
  input  except_t          exc,
  input  logic [IRQ_W-1:0] irq_pending,
  input  logic             irq_global_en,
  input  logic [1:0]       cur_priv,
  output logic             is_trap,
  output logic             is_irq,
  output logic             is_xret,
  output logic [XLEN-1:0]  cause,
  output xret_kind_t       xret_kind,
  output logic             use_tval
);

  logic [4:0] code;

  // One priority chain: interrupts, then exceptions, then xret as last resort
  always_comb begin
    is_trap   = 1'b1;
    is_irq    = 1'b0;
    is_xret   = 1'b0;
    use_tval  = 1'b0;
    code      = 5'd0;
    xret_kind = XRET_U;
    if (irq_global_en && (|irq_pending)) begin
      is_irq = 1'b1;
      if (irq_pending[IRQ_BIT_MEI])      code = IRQ_MEI;
      else if (irq_pending[IRQ_BIT_MSI]) code = IRQ_MSI;
      else if (irq_pending[IRQ_BIT_MTI]) code = IRQ_MTI;
      else if (irq_pending[IRQ_BIT_SEI]) code = IRQ_SEI;
      else if (irq_pending[IRQ_BIT_SSI]) code = IRQ_SSI;
      else                               code = IRQ_STI;
    end else if (exc.breakpoint) begin
      code = EXC_BREAKPOINT;
    end else if (exc.fetch_pagefault) begin
      code = EXC_FETCH_PAGEFAULT; use_tval = 1'b1;
    end else if (exc.fetch_access_fault) begin
      code = EXC_FETCH_ACCESS; use_tval = 1'b1;
    end else if (exc.illegal_inst) begin
      code = EXC_ILLEGAL_INST; use_tval = 1'b1;
    end else if (exc.fetch_misalign) begin
      code = EXC_FETCH_MISALIGN; use_tval = 1'b1;
    end else if (exc.ecall) begin
      code = EXC_ECALL_BASE + {3'b000, cur_priv};
    end else if (exc.store_misalign) begin
      code = EXC_STORE_MISALIGN; use_tval = 1'b1;
    end else if (exc.load_misalign) begin
      code = EXC_LOAD_MISALIGN; use_tval = 1'b1;
    end else if (exc.store_pagefault) begin
      code = EXC_STORE_PAGEFAULT; use_tval = 1'b1;
    end else if (exc.load_pagefault) begin
      code = EXC_LOAD_PAGEFAULT; use_tval = 1'b1;
    end else if (exc.store_access_fault) begin
      code = EXC_STORE_ACCESS; use_tval = 1'b1;
    end else if (exc.load_access_fault) begin
      code = EXC_LOAD_ACCESS; use_tval = 1'b1;
    end else begin
      is_trap = 1'b0;
      if (exc.mret) begin
        is_xret = 1'b1; xret_kind = XRET_M;
      end else if (exc.sret) begin
        is_xret = 1'b1; xret_kind = XRET_S;
      end else if (exc.uret) begin
        is_xret = 1'b1; xret_kind = XRET_U;
      end
    end
  end

  assign cause = {is_irq, {(XLEN-6){1'b0}}, code};

endmodule

// File: rtl/trap_ctrl.sv
// Commit-stage trap controller: captures the winning trap/xret, flushes the
// pipeline, strobes the CSR file once, then redirects fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IRQ_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic [XLEN-1:0]  commit_pc,
  input  except_t          commit_except,
  input  logic [XLEN-1:0]  commit_tval,
  input  logic [1:0]       cur_priv,
  input  logic [IRQ_W-1:0] irq_pending,
  input  logic             irq_global_en,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  input  logic [XLEN-1:0]  sepc,
  input  logic [XLEN-1:0]  uepc,
  output logic             csr_trap_we,
  output logic [XLEN-1:0]  csr_cause,
  output logic [XLEN-1:0]  csr_epc,
  output logic [XLEN-1:0]  csr_tval,
  output logic             csr_xret_we,
  output logic [1:0]       csr_xret_kind,
  output logic             flush,
  input  logic             flush_ack,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready
);

  trap_state_t     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;
  xret_kind_t      kind_q, kind_d;
  logic            xret_q, xret_d;
  logic            strobe_q, strobe_d;

  logic            is_trap, is_irq, is_xret, use_tval;
  logic [XLEN-1:0] cause;
  xret_kind_t      xret_kind;
  logic            take_event;
  logic [XLEN-1:0] trap_base, vec_off, target_now;

  trap_prio_enc #(.XLEN(XLEN), .IRQ_W(IRQ_W)) u_prio (
    .exc           (commit_except),
    .irq_pending   (irq_pending),
    .irq_global_en (irq_global_en),
    .cur_priv      (cur_priv),
    .is_trap       (is_trap),
    .is_irq        (is_irq),
    .is_xret       (is_xret),
    .cause         (cause),
    .xret_kind     (xret_kind),
    .use_tval      (use_tval)
  );

  assign take_event = (state_q == IDLE) && commit_valid && (is_trap || is_xret);
  assign trap_base  = {mtvec[XLEN-1:2], 2'b00};
  assign vec_off    = {{(XLEN-7){1'b0}}, cause[4:0], 2'b00};

  always_comb begin
    target_now = trap_base;
    if (is_xret) begin
      case (xret_kind)
        XRET_M:  target_now = mepc;
        XRET_S:  target_now = sepc;
        default: target_now = uepc;
      endcase
    end else if (is_irq && (mtvec[1:0] == 2'b01)) begin
      target_now = trap_base + vec_off;
    end
  end

  always_comb begin
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    kind_d   = kind_q;
    xret_d   = xret_q;
    if (take_event) begin
      cause_d  = cause;
      epc_d    = commit_pc;
      tval_d   = use_tval ? commit_tval : '0;
      target_d = target_now;
      kind_d   = xret_kind;
      xret_d   = is_xret;
    end
  end

  // strobe_q is high only in the first REDIRECT cycle, giving one CSR write per event
  assign strobe_d = (state_q == FLUSH) && flush_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (take_event) state_d = FLUSH;
      FLUSH:    if (flush_ack) state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      kind_q   <= XRET_U;
      xret_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      kind_q   <= kind_d;
      xret_q   <= xret_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    commit_ready   = (state_q == IDLE);
    flush          = (state_q == FLUSH);
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = target_q;
    csr_trap_we    = strobe_q && !xret_q;
    csr_xret_we    = strobe_q && xret_q;
    csr_cause      = cause_q;
    csr_epc        = epc_q;
    csr_tval       = tval_q;
    csr_xret_kind  = kind_q;
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed, table-driven bench for trap_ctrl: each vector runs a full
// commit -> flush -> CSR strobe -> redirect sequence with hand-computed results.
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam logic [14:0] X_NONE = 15'h0000;
  localparam logic [14:0] X_BRK  = 15'h4000;
  localparam logic [14:0] X_FPF  = 15'h2000;
  localparam logic [14:0] X_ILL  = 15'h0800;
  localparam logic [14:0] X_FMIS = 15'h0400;
  localparam logic [14:0] X_ECAL = 15'h0200;
  localparam logic [14:0] X_LMIS = 15'h0080;
  localparam logic [14:0] X_SPF  = 15'h0040;
  localparam logic [14:0] X_LPF  = 15'h0020;
  localparam logic [14:0] X_SAF  = 15'h0010;
  localparam logic [14:0] X_MRET = 15'h0004;
  localparam logic [14:0] X_SRET = 15'h0002;
  localparam logic [14:0] X_URET = 15'h0001;

  localparam logic [31:0] MEPC = 32'h8000_2000;
  localparam logic [31:0] SEPC = 32'h8000_3000;
  localparam logic [31:0] UEPC = 32'h0000_1000;

  typedef struct {
    logic [14:0] exc;
    logic [5:0]  irq;
    logic        gen;
    logic [1:0]  priv;
    logic [31:0] pc;
    logic [31:0] tval;
    logic [31:0] mtvec;
    int          stall;
    logic        xret;
    logic [31:0] e_cause;
    logic [31:0] e_tval;
    logic [31:0] e_target;
    logic [1:0]  e_kind;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  except_t     commit_except;
  logic [31:0] commit_tval;
  logic [1:0]  cur_priv;
  logic [5:0]  irq_pending;
  logic        irq_global_en;
  logic [31:0] mtvec, mepc, sepc, uepc;
  logic        csr_trap_we;
  logic [31:0] csr_cause, csr_epc, csr_tval;
  logic        csr_xret_we;
  logic [1:0]  csr_xret_kind;
  logic        flush;
  logic        flush_ack;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  int checks_total  = 0;
  int checks_passed = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(32), .IRQ_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .commit_valid   (commit_valid),
    .commit_ready   (commit_ready),
    .commit_pc      (commit_pc),
    .commit_except  (commit_except),
    .commit_tval    (commit_tval),
    .cur_priv       (cur_priv),
    .irq_pending    (irq_pending),
    .irq_global_en  (irq_global_en),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .sepc           (sepc),
    .uepc           (uepc),
    .csr_trap_we    (csr_trap_we),
    .csr_cause      (csr_cause),
    .csr_epc        (csr_epc),
    .csr_tval       (csr_tval),
    .csr_xret_we    (csr_xret_we),
    .csr_xret_kind  (csr_xret_kind),
    .flush          (flush),
    .flush_ack      (flush_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    commit_except = except_t'(v.exc);
    irq_pending   = v.irq;
    irq_global_en = v.gen;
    cur_priv      = v.priv;
    commit_pc     = v.pc;
    commit_tval   = v.tval;
    mtvec         = v.mtvec;
    mepc          = MEPC;
    sepc          = SEPC;
    uepc          = UEPC;
  endtask

  task automatic scramble_inputs();
    commit_except = except_t'(X_NONE);
    irq_pending   = 6'h3F;
    irq_global_en = 1'b1;
    commit_pc     = 32'hDEAD_0000;
    commit_tval   = 32'hDEAD_1111;
    mtvec         = 32'h4000_0001;
    mepc          = 32'hBAD0_0000;
    sepc          = 32'hBAD1_0000;
    uepc          = 32'hBAD2_0000;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    $display("[TB] vector %0d", idx);
    applyStimulus(v);
    commit_valid = 1'b1;
    #1;
    checkOutput("ready_idle", {31'b0, commit_ready}, 32'd1);
    tick();
    commit_valid = 1'b0;
    scramble_inputs();
    checkOutput("flush_raised", {31'b0, flush}, 32'd1);
    checkOutput("ready_busy", {31'b0, commit_ready}, 32'd0);
    checkOutput("no_early_strobe", {30'b0, csr_trap_we, csr_xret_we}, 32'd0);
    tick();
    checkOutput("flush_held", {31'b0, flush}, 32'd1);
    flush_ack = 1'b1;
    tick();
    flush_ack = 1'b0;
    checkOutput("flush_dropped", {31'b0, flush}, 32'd0);
    checkOutput("redirect_valid", {31'b0, redirect_valid}, 32'd1);
    checkOutput("trap_we", {31'b0, csr_trap_we}, {31'b0, !v.xret});
    checkOutput("xret_we", {31'b0, csr_xret_we}, {31'b0, v.xret});
    checkOutput("redirect_pc", redirect_pc, v.e_target);
    if (v.xret) begin
      checkOutput("xret_kind", {30'b0, csr_xret_kind}, {30'b0, v.e_kind});
    end else begin
      checkOutput("cause", csr_cause, v.e_cause);
      checkOutput("epc", csr_epc, v.pc);
      checkOutput("tval", csr_tval, v.e_tval);
    end
    redirect_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      tick();
      checkOutput("stall_strobes", {30'b0, csr_trap_we, csr_xret_we}, 32'd0);
      checkOutput("stall_valid", {31'b0, redirect_valid}, 32'd1);
      checkOutput("stall_pc", redirect_pc, v.e_target);
    end
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    checkOutput("back_idle_valid", {31'b0, redirect_valid}, 32'd0);
    checkOutput("back_idle_ready", {31'b0, commit_ready}, 32'd1);
  endtask

  initial begin
    //        exc               irq    gen   priv  pc             tval           mtvec        stall xret  cause          tval           target         kind
    vecs[0]  = '{X_LPF,          6'h00, 1'b0, 2'd3, 32'h8000_0100, 32'h1234_5000, 32'h8000_0000, 0, 1'b0, 32'd13,        32'h1234_5000, 32'h8000_0000, 2'd0};
    vecs[1]  = '{X_ILL|X_LMIS|X_SPF, 6'h00, 1'b0, 2'd3, 32'h8000_0200, 32'hDEAD_BEEF, 32'h8000_0000, 0, 1'b0, 32'd2, 32'hDEAD_BEEF, 32'h8000_0000, 2'd0};
    vecs[2]  = '{X_ECAL,         6'h00, 1'b0, 2'd1, 32'h8000_0300, 32'h0000_0055, 32'h8000_0001, 1, 1'b0, 32'd9,         32'h0,         32'h8000_0000, 2'd0};
    vecs[3]  = '{X_FMIS,         6'h09, 1'b1, 2'd3, 32'h8000_0400, 32'h0000_0066, 32'h8000_0001, 0, 1'b0, 32'h8000_0007, 32'h0,         32'h8000_001C, 2'd0};
    vecs[4]  = '{X_MRET,         6'h00, 1'b0, 2'd3, 32'h8000_0500, 32'h0,         32'h8000_0000, 3, 1'b1, 32'd0,         32'h0,         MEPC,          2'd3};
    vecs[5]  = '{X_BRK,          6'h3F, 1'b0, 2'd3, 32'h8000_0600, 32'h0000_0077, 32'h8000_0000, 0, 1'b0, 32'd3,         32'h0,         32'h8000_0000, 2'd0};
    vecs[6]  = '{X_SRET|X_SAF,   6'h00, 1'b1, 2'd1, 32'h8000_0700, 32'h0000_0088, 32'h8000_0010, 0, 1'b0, 32'd7,         32'h0000_0088, 32'h8000_0010, 2'd0};
    vecs[7]  = '{X_SRET,         6'h00, 1'b0, 2'd1, 32'h8000_0800, 32'h0,         32'h8000_0000, 1, 1'b1, 32'd0,         32'h0,         SEPC,          2'd1};
    vecs[8]  = '{X_URET,         6'h00, 1'b0, 2'd0, 32'h8000_0900, 32'h0,         32'h8000_0000, 0, 1'b1, 32'd0,         32'h0,         UEPC,          2'd0};
    vecs[9]  = '{X_NONE,         6'h3F, 1'b1, 2'd3, 32'h8000_0A00, 32'h0000_0099, 32'hFFFF_FFFD, 0, 1'b0, 32'h8000_000B, 32'h0,         32'h0000_0028, 2'd0};
    vecs[10] = '{X_ECAL,         6'h00, 1'b0, 2'd0, 32'h8000_0B00, 32'h0,         32'h8000_0000, 0, 1'b0, 32'd8,         32'h0,         32'h8000_0000, 2'd0};
    vecs[11] = '{X_ECAL|X_MRET,  6'h00, 1'b0, 2'd3, 32'h8000_0C00, 32'h0,         32'h8000_0000, 0, 1'b0, 32'd11,        32'h0,         32'h8000_0000, 2'd0};
    vecs[12] = '{X_NONE,         6'h04, 1'b1, 2'd1, 32'h8000_0D00, 32'h0,         32'h0000_0101, 0, 1'b0, 32'h8000_0009, 32'h0,         32'h0000_0124, 2'd0};
    vecs[13] = '{X_FPF|X_BRK,    6'h00, 1'b0, 2'd3, 32'h8000_0E00, 32'h0000_00AA, 32'h8000_0000, 0, 1'b0, 32'd3,         32'h0,         32'h8000_0000, 2'd0};

    rst_n          = 1'b0;
    commit_valid   = 1'b0;
    flush_ack      = 1'b0;
    redirect_ready = 1'b0;
    applyStimulus(vecs[0]);
    repeat (3) tick();
    checkOutput("rst_ready", {31'b0, commit_ready}, 32'd1);
    checkOutput("rst_flush", {31'b0, flush}, 32'd0);
    checkOutput("rst_redirect", {31'b0, redirect_valid}, 32'd0);
    checkOutput("rst_strobes", {30'b0, csr_trap_we, csr_xret_we}, 32'd0);
    checkOutput("rst_pc", redirect_pc, 32'd0);
    checkOutput("rst_cause", csr_cause, 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain commit: no event, stays IDLE
    commit_except = except_t'(X_NONE);
    irq_pending   = 6'h00;
    commit_valid  = 1'b1;
    #1;
    checkOutput("plain_ready", {31'b0, commit_ready}, 32'd1);
    tick();
    commit_valid = 1'b0;
    checkOutput("plain_no_flush", {31'b0, flush}, 32'd0);
    checkOutput("plain_still_ready", {31'b0, commit_ready}, 32'd1);
    checkOutput("plain_no_strobe", {30'b0, csr_trap_we, csr_xret_we}, 32'd0);

    // Pending interrupt without a committing instruction is not sampled
    irq_pending   = 6'h20;
    irq_global_en = 1'b1;
    tick();
    tick();
    checkOutput("novalid_no_flush", {31'b0, flush}, 32'd0);
    irq_pending = 6'h00;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Asynchronous reset while flushing aborts the sequence
    applyStimulus(vecs[0]);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    checkOutput("abort_flush_up", {31'b0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_flush_down", {31'b0, flush}, 32'd0);
    checkOutput("abort_ready", {31'b0, commit_ready}, 32'd1);
    flush_ack      = 1'b1;
    redirect_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_no_strobe", {30'b0, csr_trap_we, csr_xret_we}, 32'd0);
      checkOutput("abort_no_redirect", {31'b0, redirect_valid}, 32'd0);
      checkOutput("abort_no_flush", {31'b0, flush}, 32'd0);
    end
    flush_ack      = 1'b0;
    redirect_ready = 1'b0;

    // Controller must still work after the aborted sequence
    run_vec(99, vecs[3]);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
